// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads pre-empt clear fills, which pre-empt writer writes.
// Memory access is combinational in the granting cycle; PixelOut lags its coordinate by two cycles; WrReady drops on display slots and ClearReq.
module fb_arbiter #(
    parameter int BYTES_PER_LINE = 80,
    parameter int MEM_DEPTH      = 38400,
    parameter int ADDR_W         = 16
) (
    input  logic              CLK_25,
    input  logic              Reset,
    input  logic [9:0]        PixelX,
    input  logic [9:0]        PixelY,
    input  logic              InDisplayArea,
    input  logic              WrValid,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [7:0]        WrData,
    output logic              WrReady,
    input  logic              ClearReq,
    input  logic [7:0]        ClearData,
    output logic              ClearBusy,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWe,
    output logic [7:0]        MemWrData,
    input  logic [7:0]        MemRdData,
    output logic              PixelOut,
    output logic [7:0]        DropCnt
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        fill_q;
    logic [7:0]        drop_q;
    logic              vis_q;
    logic              slot_q;
    logic [2:0]        xlo_q;
    logic [7:0]        byte_q;
    logic              pix_out_q;

    logic              slot;
    logic              wr_rdy;
    logic              wr_acc;
    logic              wr_drop;
    logic              clr_wr;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] addr_d;
    logic              we_d;
    logic [7:0]        wdat_d;
    logic [7:0]        byte_cur;

    always_comb begin
        slot      = InDisplayArea && (PixelX[2:0] == 3'd0);
        disp_addr = ADDR_W'(PixelY) * ADDR_W'(BYTES_PER_LINE) + ADDR_W'(PixelX[9:3]);
        wr_rdy    = Reset && (state_q == IDLE) && !slot && !ClearReq;
        wr_acc    = wr_rdy && WrValid;
        wr_drop   = wr_acc && (WrAddr > LAST_ADDR);
        clr_wr    = (state_q == CLEAR) && !slot;
        addr_d    = mem_addr_q;
        we_d      = 1'b0;
        wdat_d    = 8'h00;
        if (slot) begin
            addr_d = disp_addr;
        end else if (clr_wr) begin
            addr_d = ptr_q;
            we_d   = 1'b1;
            wdat_d = fill_q;
        end else if (wr_acc && !wr_drop) begin
            addr_d = WrAddr;
            we_d   = 1'b1;
            wdat_d = WrData;
        end
        // Reset forces the RAM port quiet immediately, not just at the next edge.
        if (!Reset) begin
            addr_d = '0;
            we_d   = 1'b0;
            wdat_d = 8'h00;
        end
        // The RAM returns the slot byte one cycle late; later pixels of the group reuse the held copy.
        byte_cur = slot_q ? MemRdData : byte_q;
    end

    always_ff @(posedge CLK_25 or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            fill_q     <= 8'h00;
            drop_q     <= 8'h00;
            mem_addr_q <= '0;
            vis_q      <= 1'b0;
            slot_q     <= 1'b0;
            xlo_q      <= 3'd0;
            byte_q     <= 8'h00;
            pix_out_q  <= 1'b0;
        end else begin
            mem_addr_q <= addr_d;
            vis_q      <= InDisplayArea;
            slot_q     <= slot;
            xlo_q      <= PixelX[2:0];
            byte_q     <= byte_cur;
            pix_out_q  <= vis_q & byte_cur[3'd7 - xlo_q];
            if (wr_drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            if (state_q == IDLE) begin
                if (ClearReq) begin
                    state_q <= CLEAR;
                    busy_q  <= 1'b1;
                    ptr_q   <= '0;
                    fill_q  <= ClearData;
                end
            end else if (clr_wr) begin
                ptr_q <= ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign WrReady   = wr_rdy;
    assign ClearBusy = busy_q;
    assign MemAddr   = addr_d;
    assign MemWe     = we_d;
    assign MemWrData = wdat_d;
    assign PixelOut  = pix_out_q;
    assign DropCnt   = drop_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: RAM model, rule-based reference checked every cycle, vector table and corner sequences.
module tb_fb_arbiter;
    logic        CLK_25 = 1'b0;
    logic        Reset;
    logic [9:0]  PixelX, PixelY;
    logic        InDisplayArea, WrValid, WrReady, ClearReq, ClearBusy, MemWe, PixelOut;
    logic [15:0] WrAddr, MemAddr;
    logic [7:0]  WrData, ClearData, MemWrData, MemRdData, DropCnt;

    always #5 CLK_25 = ~CLK_25;

    fb_arbiter dut (
        .CLK_25(CLK_25), .Reset(Reset), .PixelX(PixelX), .PixelY(PixelY),
        .InDisplayArea(InDisplayArea), .WrValid(WrValid), .WrAddr(WrAddr), .WrData(WrData),
        .WrReady(WrReady), .ClearReq(ClearReq), .ClearData(ClearData), .ClearBusy(ClearBusy),
        .MemAddr(MemAddr), .MemWe(MemWe), .MemWrData(MemWrData), .MemRdData(MemRdData),
        .PixelOut(PixelOut), .DropCnt(DropCnt)
    );

    // Single-port RAM with one-cycle read latency.
    logic [7:0] ram [65536];
    logic [7:0] rd_q;
    assign MemRdData = rd_q;
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        rd_q = 8'h00;
        forever begin
            @(posedge CLK_25);
            rd_q <= ram[MemAddr];
            if (MemWe) ram[MemAddr] <= MemWrData;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model state
    typedef struct packed { logic e; logic c; } pix_t;
    pix_t       pq[$];
    logic [7:0] refmem [65536];
    bit         m_busy, m_last_ok, pix_chk;
    int         m_ptr, m_drop, m_last, busy_cnt, we_cnt;
    logic [7:0] m_fill;

    task automatic model_reset();
        pix_t z;
        z = '0;
        m_busy = 0; m_ptr = 0; m_drop = 0; m_last = 0; m_last_ok = 1;
        pq.delete();
        pq.push_back(z);
        pq.push_back(z);
    endtask

    task automatic drive(input bit disp, input int x, input int y, input bit wv, input int wa,
                         input logic [7:0] wd, input bit cr, input logic [7:0] cd);
        pix_t       p;
        bit         slot, rdy, busy0;
        logic [7:0] b;
        @(posedge CLK_25); #1;
        InDisplayArea = disp; PixelX = 10'(x); PixelY = 10'(y);
        WrValid = wv; WrAddr = 16'(wa); WrData = wd; ClearReq = cr; ClearData = cd;
        #1;
        p = pq.pop_front();
        if (p.c) chk("pixel", PixelOut, p.e);
        b = refmem[y * 80 + x / 8];
        p.e = disp ? b[7 - x % 8] : 1'b0;
        p.c = pix_chk;
        pq.push_back(p);
        chk("clear_busy", ClearBusy, m_busy);
        chk("drop_cnt", DropCnt, m_drop);
        if (ClearBusy) busy_cnt++;
        if (MemWe) we_cnt++;
        busy0 = m_busy;
        slot  = disp && (x % 8 == 0);
        rdy   = !m_busy && !slot && !cr;
        chk("wr_ready", WrReady, rdy);
        if (slot) begin
            chk("disp_we", MemWe, 0);
            chk("disp_addr", MemAddr, y * 80 + x / 8);
            m_last = y * 80 + x / 8; m_last_ok = 1;
        end else if (m_busy) begin
            chk("clr_we", MemWe, 1);
            chk("clr_addr", MemAddr, m_ptr);
            chk("clr_data", MemWrData, m_fill);
            refmem[m_ptr] = m_fill;
            m_last = m_ptr; m_last_ok = 1;
            if (m_ptr == 38399) m_busy = 0;
            m_ptr++;
        end else if (rdy && wv && wa < 38400) begin
            chk("wr_we", MemWe, 1);
            chk("wr_addr", MemAddr, wa);
            chk("wr_data", MemWrData, wd);
            refmem[wa] = wd;
            m_last = wa; m_last_ok = 1;
        end else begin
            chk("idle_we", MemWe, 0);
            if (rdy && wv) begin
                if (m_drop < 255) m_drop++;
                m_last_ok = 0;
            end else if (m_last_ok) begin
                chk("hold_addr", MemAddr, m_last);
            end
        end
        if (!busy0 && cr) begin
            m_busy = 1; m_ptr = 0; m_fill = cd;
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge CLK_25); #1;
        Reset = 0;
        #1;
        chk("rst_wr_ready", WrReady, 0);
        chk("rst_we", MemWe, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_wdata", MemWrData, 0);
        chk("rst_pixel", PixelOut, 0);
        chk("rst_drop", DropCnt, 0);
        chk("rst_busy", ClearBusy, 0);
        repeat (2) @(posedge CLK_25);
        #1;
        Reset = 1;
        model_reset();
    endtask

    typedef struct {
        bit disp; int x; int y; bit wv; int wa; logic [7:0] wd;
        bit rdy; bit we; bit ca; int addr; logic [7:0] dat;
    } vec_t;

    initial begin
        vec_t       tbl [8];
        logic [7:0] pat;
        logic       obs [10];
        int         mism, prev, mono_err, n;
        bit         first;

        tbl[0] = '{1, 0,   0,   1, 5,     8'h11, 0, 0, 1, 0,     8'h00};
        tbl[1] = '{1, 8,   2,   1, 6,     8'h22, 0, 0, 1, 161,   8'h00};
        tbl[2] = '{1, 3,   2,   1, 100,   8'h3C, 1, 1, 1, 100,   8'h3C};
        tbl[3] = '{0, 0,   0,   1, 38399, 8'h77, 1, 1, 1, 38399, 8'h77};
        tbl[4] = '{1, 639, 479, 0, 0,     8'h00, 1, 0, 1, 38399, 8'h00};
        tbl[5] = '{1, 632, 478, 1, 200,   8'h44, 0, 0, 1, 38319, 8'h00};
        tbl[6] = '{0, 0,   0,   1, 38400, 8'h99, 1, 0, 0, 0,     8'h00};
        tbl[7] = '{0, 0,   0,   0, 0,     8'h00, 1, 0, 0, 0,     8'h00};

        for (int i = 0; i < 65536; i++) refmem[i] = 8'h00;
        pix_chk = 0; busy_cnt = 0; we_cnt = 0; m_fill = 8'h00;
        InDisplayArea = 1; PixelX = 0; PixelY = 0; WrValid = 1; WrAddr = 16'd3;
        WrData = 8'h12; ClearReq = 0; ClearData = 8'h00;
        Reset = 0;
        #3;
        chk("init_wr_ready", WrReady, 0);
        chk("init_we", MemWe, 0);
        chk("init_addr", MemAddr, 0);
        chk("init_pixel", PixelOut, 0);
        chk("init_drop", DropCnt, 0);
        chk("init_busy", ClearBusy, 0);
        repeat (2) @(posedge CLK_25);
        #1;
        Reset = 1;
        model_reset();

        // WrReady comes up on the first non-slot cycle after release
        drive(1, 16, 0, 1, 7, 8'h01, 0, 8'h00);
        chk("rdy_slot_after_reset", WrReady, 0);
        drive(0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        chk("rdy_after_reset", WrReady, 1);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].disp, tbl[i].x, tbl[i].y, tbl[i].wv, tbl[i].wa, tbl[i].wd, 0, 8'h00);
            chk($sformatf("vec%0d_rdy", i), WrReady, tbl[i].rdy);
            chk($sformatf("vec%0d_we", i), MemWe, tbl[i].we);
            if (tbl[i].ca) chk($sformatf("vec%0d_addr", i), MemAddr, tbl[i].addr);
            if (tbl[i].we) chk($sformatf("vec%0d_data", i), MemWrData, tbl[i].dat);
        end
        drive(0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        chk("vec_drop_cnt", DropCnt, 1);

        // 0xA5 at byte 0 scans out MSB first
        drive(0, 0, 0, 1, 0, 8'hA5, 0, 8'h00);
        pix_chk = 1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1, k, 0, 0, 0, 8'h00, 0, 8'h00);
            else       drive(0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
            obs[k] = PixelOut;
        end
        pat = 8'hA5;
        for (int k = 0; k < 8; k++) chk($sformatf("a5_bit_x%0d", k), obs[k + 2], pat[7 - k]);
        blank(2);
        pix_chk = 0;

        // writer held valid across a visible line
        we_cnt = 0;
        for (int x = 0; x < 640; x++) drive(1, x, 0, 1, 30000 + x, 8'(x), 0, 8'h00);
        chk("line_writes", we_cnt, 560);
        blank(2);

        for (int i = 0; i < 600; i++) begin
            n = $urandom % 8;
            drive($urandom % 2, $urandom % 640, $urandom % 480, $urandom % 2,
                  (n == 0) ? 38400 + $urandom % 100 : (n < 4) ? $urandom % 240 : $urandom % 38400,
                  8'($urandom), 0, 8'h00);
        end
        blank(1);
        mism = 0;
        for (int a = 0; a < 38400; a++) if (ram[a] !== refmem[a]) mism++;
        chk("ram_vs_model", mism, 0);

        pix_chk = 1;
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 640; x++) drive(1, x, y, 0, 0, 8'h00, 0, 8'h00);
            blank(4);
        end
        pix_chk = 0;

        we_cnt = 0;
        repeat (300) drive(0, 0, 0, 1, 38400, 8'h5A, 0, 8'h00);
        chk("drop_no_we", we_cnt, 0);
        drive(0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        chk("drop_saturated", DropCnt, 255);

        // full clear started together with a write; a second ClearReq mid-fill is ignored
        drive(0, 0, 0, 1, 123, 8'h42, 1, 8'hFF);
        chk("clr_start_we", MemWe, 0);
        chk("clr_start_rdy", WrReady, 0);
        busy_cnt = 0; mono_err = 0; first = 1; prev = 0;
        for (int i = 0; i < 40000; i++) begin
            drive(0, i % 640, 0, $urandom % 2, $urandom % 38400, 8'h42, i == 20000, 8'h00);
            if (ClearBusy && MemWe) begin
                if (!first && MemAddr != 16'(prev + 1)) mono_err++;
                if (first && MemAddr != 16'd0) mono_err++;
                first = 0;
                prev = MemAddr;
            end
            if (!ClearBusy) break;
        end
        chk("clr_ended", ClearBusy, 0);
        chk("clr_busy_cycles", busy_cnt, 38400);
        chk("clr_monotonic", mono_err, 0);
        mism = 0;
        for (int a = 0; a < 38400; a++) if (ram[a] !== 8'hFF) mism++;
        chk("clr_fill_ff", mism, 0);

        // partial clear with display slots, abandoned by reset at pointer 1000
        drive(0, 0, 0, 0, 0, 8'h00, 1, 8'h00);
        for (int i = 0; i < 5000 && m_ptr != 1000; i++)
            drive(($urandom % 3) == 0, ($urandom % 80) * 8 + (($urandom % 2) ? 0 : 1),
                  $urandom % 480, 0, 0, 8'h00, 0, 8'h00);
        chk("ptr_reached_1000", m_ptr, 1000);
        do_reset();
        blank(20);
        chk("abandon_busy", ClearBusy, 0);
        chk("abandon_addr1000", ram[1000], 8'hFF);
        chk("abandon_addr999", ram[999], 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
